cmp_qualifier: RTL

Sequential qualifier sitting directly downstream of `comparator_3bit`. It samples the comparator's one-hot `eq`/`gt`/`lt` flags under a valid strobe and debounces them into a stable qualified relation. It flags glitches and illegal flag combinations, and keeps saturating per-relation occurrence counters for the status/readout logic further downstream.

---
 rtl/cmp_pkg.sv | 32 +++
 rtl/sat_counter.sv | 30 +++
 rtl/cmp_qualifier.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared relation codes, FSM state encoding and flag decoding for the
// comparator qualifier.
package cmp_pkg;

    typedef enum logic [1:0] {
        REL_EQ   = 2'd0,
        REL_GT   = 2'd1,
        REL_LT   = 2'd2,
        REL_NONE = 2'd3
    } rel_e;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        STABLE  = 2'd1,
        PENDING = 2'd2
    } state_e;

    localparam int STREAK_W = 4;

    // Anything other than exactly one flag set decodes to REL_NONE.
    function automatic rel_e flags_to_rel(input logic eq, input logic gt, input logic lt);
        rel_e rel;
        case ({eq, gt, lt})
            3'b100:  rel = REL_EQ;
            3'b010:  rel = REL_GT;
            3'b001:  rel = REL_LT;
            default: rel = REL_NONE;
        endcase
        return rel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over
// the increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_count;

    // NOTE: registered state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != MAX)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/cmp_qualifier.sv
// Debounces one-hot comparator flags into a qualified relation, flags glitches
// and illegal samples, and counts legal samples per relation.
module cmp_qualifier #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    input  logic             clr,
    output logic [1:0]       qual_rel,
    output logic             qual_valid,
    output logic             change,
    output logic             glitch,
    output logic             err,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    import cmp_pkg::*;

    localparam logic [STREAK_W-1:0] DEB = STREAK_W'(DEBOUNCE);

    state_e              r_state,      w_state_nxt;
    rel_e                r_cand,       w_cand_nxt;
    logic [STREAK_W-1:0] r_streak,     w_streak_nxt;
    rel_e                r_qual_rel,   w_qual_rel_nxt;
    logic                r_qual_valid, w_qual_valid_nxt;
    logic                r_change,     w_change_nxt;
    logic                r_glitch,     w_glitch_nxt;
    logic                r_err,        w_err_nxt;

    rel_e                w_rel;
    logic                w_legal;
    logic                w_illegal;
    logic [STREAK_W-1:0] w_streak_inc;

    assign w_rel        = flags_to_rel(eq, gt, lt);
    assign w_legal      = in_valid && (w_rel != REL_NONE);
    assign w_illegal    = in_valid && (w_rel == REL_NONE);
    assign w_streak_inc = r_streak + STREAK_W'(1);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_cand_nxt       = r_cand;
        w_streak_nxt     = r_streak;
        w_qual_rel_nxt   = r_qual_rel;
        w_qual_valid_nxt = r_qual_valid;
        w_change_nxt     = 1'b0;
        w_glitch_nxt     = 1'b0;
        w_err_nxt        = 1'b0;

        if (w_illegal) begin
            w_err_nxt = 1'b1;
            if (r_state == PENDING) begin
                w_state_nxt = STABLE;
            end else if (r_state == UNKNOWN) begin
                w_streak_nxt = '0;
            end
        end else if (w_legal) begin
            case (r_state)
                UNKNOWN: begin
                    if ((w_rel == r_cand) && (r_streak != '0)) begin
                        w_streak_nxt = w_streak_inc;
                    end else begin
                        w_cand_nxt   = w_rel;
                        w_streak_nxt = STREAK_W'(1);
                    end
                    if (w_streak_nxt == DEB) begin
                        w_qual_rel_nxt   = w_cand_nxt;
                        w_qual_valid_nxt = 1'b1;
                        w_change_nxt     = 1'b1;
                        w_streak_nxt     = '0;
                        w_state_nxt      = STABLE;
                    end
                end
                STABLE: begin
                    if (w_rel != r_qual_rel) begin
                        // A single-sample debounce qualifies without visiting PENDING.
                        if (DEBOUNCE == 1) begin
                            w_qual_rel_nxt = w_rel;
                            w_change_nxt   = 1'b1;
                        end else begin
                            w_cand_nxt   = w_rel;
                            w_streak_nxt = STREAK_W'(1);
                            w_state_nxt  = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (w_rel == r_cand) begin
                        w_streak_nxt = w_streak_inc;
                        if (w_streak_inc == DEB) begin
                            w_qual_rel_nxt = r_cand;
                            w_change_nxt   = 1'b1;
                            w_streak_nxt   = '0;
                            w_state_nxt    = STABLE;
                        end
                    end else if (w_rel == r_qual_rel) begin
                        w_glitch_nxt = 1'b1;
                        w_state_nxt  = STABLE;
                    end else begin
                        w_glitch_nxt = 1'b1;
                        w_cand_nxt   = w_rel;
                        w_streak_nxt = STREAK_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = UNKNOWN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= UNKNOWN;
            r_cand       <= REL_EQ;
            r_streak     <= '0;
            r_qual_rel   <= REL_NONE;
            r_qual_valid <= 1'b0;
            r_change     <= 1'b0;
            r_glitch     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_streak     <= w_streak_nxt;
            r_qual_rel   <= w_qual_rel_nxt;
            r_qual_valid <= w_qual_valid_nxt;
            r_change     <= w_change_nxt;
            r_glitch     <= w_glitch_nxt;
            r_err        <= w_err_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_legal && (w_rel == REL_EQ)),
        .clr   (clr),
        .count (eq_cnt)
    );

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_legal && (w_rel == REL_GT)),
        .clr   (clr),
        .count (gt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_legal && (w_rel == REL_LT)),
        .clr   (clr),
        .count (lt_cnt)
    );

    assign qual_rel   = r_qual_rel;
    assign qual_valid = r_qual_valid;
    assign change     = r_change;
    assign glitch     = r_glitch;
    assign err        = r_err;

endmodule
